// File: rtl/uart_rx_core.sv
// UART receive core: oversampled start/data/parity/stop decoding with 3-sample majority vote.
// Optional saturating error counter output err_cnt, enabled by defining RX_ERR_CNT_EN.
module uart_rx_core #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic [5:0]        Prescale,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              parity_error,
    output logic              stop_error
`ifdef RX_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [5:0]          edge_cnt;
    logic [BIT_W-1:0]    bit_idx;
    logic [5:0]          presc;
    logic [5:0]          half;
    logic                par_en_q;
    logic                par_typ_q;
    logic                par_err;
    logic [2:0]          samp;
    logic [DATA_W-1:0]   shift;
    logic                last_edge;
    logic                voted;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    function automatic logic calc_parity(input logic [DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Unsupported ratios fall back to 8 so a misconfigured link still decodes something sane.
    function automatic logic [5:0] eff_prescale(input logic [5:0] p);
        case (p)
            6'd16:   return 6'd16;
            6'd32:   return 6'd32;
            default: return 6'd8;
        endcase
    endfunction

    assign half      = {1'b0, presc[5:1]};
    assign last_edge = (edge_cnt == presc - 6'd1);
    assign voted     = maj3(samp);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!RX_IN) state_nxt = START;
            end
            START: begin
                if (last_edge) state_nxt = voted ? IDLE : DATA;
            end
            DATA: begin
                if (last_edge && (bit_idx == BIT_W'(DATA_W - 1)))
                    state_nxt = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (last_edge) state_nxt = STOP;
            end
            STOP: begin
                if (last_edge) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt     <= '0;
            bit_idx      <= '0;
            presc        <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_err      <= 1'b0;
            samp         <= '0;
            shift        <= '0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            if (state == IDLE) begin
                // The detecting cycle is edge 0 of the start bit, so the count resumes at 1.
                edge_cnt <= RX_IN ? 6'd0 : 6'd1;
                bit_idx  <= '0;
                par_err  <= 1'b0;
                if (!RX_IN) begin
                    presc     <= eff_prescale(Prescale);
                    par_en_q  <= PAR_EN;
                    par_typ_q <= PAR_TYP;
                end
            end else begin
                edge_cnt <= last_edge ? 6'd0 : edge_cnt + 6'd1;
                if (edge_cnt == half - 6'd1) samp[0] <= RX_IN;
                if (edge_cnt == half)        samp[1] <= RX_IN;
                if (edge_cnt == half + 6'd1) samp[2] <= RX_IN;
                if (last_edge) begin
                    case (state)
                        DATA: begin
                            shift   <= {voted, shift[DATA_W-1:1]};
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                        PARITY: begin
                            par_err <= (voted != calc_parity(shift, par_typ_q));
                        end
                        STOP: begin
                            // A bad stop bit outranks a parity mismatch.
                            if (!voted) begin
                                stop_error <= 1'b1;
                            end else if (par_err) begin
                                parity_error <= 1'b1;
                            end else begin
                                P_DATA     <= shift;
                                data_valid <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef RX_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= 8'd0;
        end else if ((parity_error || stop_error) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames push expected strobes, a monitor pops and compares.
module tb_uart_rx_core;

    localparam logic [2:0] K_DV = 3'b001;
    localparam logic [2:0] K_PE = 3'b010;
    localparam logic [2:0] K_SE = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         at;
    } exp_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       RX_IN    = 1'b1;
    logic       PAR_EN   = 1'b0;
    logic       PAR_TYP  = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
`ifdef RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int         checks    = 0;
    int         failures  = 0;
    int         cyc       = 0;
    exp_t       sb[$];
    logic [7:0] exp_pdata = 8'h00;

    uart_rx_core #(.DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_IN        (RX_IN),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .Prescale     (Prescale),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error)
`ifdef RX_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && (data_valid || parity_error || stop_error)) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {29'd0, stop_error, parity_error, data_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", {29'd0, stop_error, parity_error, data_valid}, {29'd0, e.kind});
                check("p_data", {24'd0, P_DATA}, {24'd0, e.data});
                check("strobe_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Called on a negedge; leaves the stop bit on the line and returns on the negedge of the strobe cycle.
    task automatic send_frame(input logic [7:0] d, input logic [5:0] pset, input int p_eff,
                              input logic pen, input logic ptyp, input logic pbit,
                              input logic sbit, input logic [2:0] kind);
        exp_t e;
        Prescale = pset;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        if (kind == K_DV) exp_pdata = d;
        e.kind = kind;
        e.data = exp_pdata;
        e.at   = cyc + (pen ? 11 : 10) * p_eff;
        sb.push_back(e);
        RX_IN = 1'b0;
        repeat (p_eff) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (p_eff) @(negedge clk);
        end
        if (pen) begin
            RX_IN = pbit;
            repeat (p_eff) @(negedge clk);
        end
        RX_IN = sbit;
        repeat (p_eff) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        RX_IN = 1'b1;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("rst_p_data", {24'd0, P_DATA}, 32'd0);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_parity_error", {31'd0, parity_error}, 32'd0);
        check("rst_stop_error", {31'd0, stop_error}, 32'd0);
`ifdef RX_ERR_CNT_EN
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 0xA5 with even parity (bit 0), strobe at 88
        send_frame(8'hA5, 6'd8, 8, 1'b1, 1'b0, 1'b0, 1'b1, K_DV);
        wait_drain();

        // back-to-back 0x3C, 0xFF at prescale 16, strobes at 160 and 320
        send_frame(8'h3C, 6'd16, 16, 1'b0, 1'b0, 1'b0, 1'b1, K_DV);
        send_frame(8'hFF, 6'd16, 16, 1'b0, 1'b0, 1'b0, 1'b1, K_DV);
        wait_drain();

        // odd parity of 0x01 is 0, sending 1 is a parity error
        send_frame(8'h01, 6'd8, 8, 1'b1, 1'b1, 1'b1, 1'b1, K_PE);
        wait_drain();

        // bad stop and bad parity together: stop error only
        send_frame(8'h01, 6'd8, 8, 1'b1, 1'b1, 1'b1, 1'b0, K_SE);
        wait_drain();
`ifdef RX_ERR_CNT_EN
        check("err_cnt_two", {24'd0, err_cnt}, 32'd2);
`endif

        // 3-cycle glitch must not produce any strobe
        Prescale = 6'd8;
        RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        RX_IN = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_p_data", {24'd0, P_DATA}, 32'h0000_00FF);
        send_frame(8'h55, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, K_DV);
        wait_drain();

        // illegal prescale 12 behaves as 8
        send_frame(8'hC3, 6'd12, 8, 1'b0, 1'b0, 1'b0, 1'b1, K_DV);
        wait_drain();

        // prescale 32, even parity of 0x3C is 0, strobe at 352
        send_frame(8'h3C, 6'd32, 32, 1'b1, 1'b0, 1'b0, 1'b1, K_DV);
        wait_drain();

        // reset during bit 4 of a 0x5A frame
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX_IN = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (8) @(negedge clk);
        end
        RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_p_data", {24'd0, P_DATA}, 32'd0);
        check("midrst_data_valid", {31'd0, data_valid}, 32'd0);
        check("midrst_parity_error", {31'd0, parity_error}, 32'd0);
        check("midrst_stop_error", {31'd0, stop_error}, 32'd0);
`ifdef RX_ERR_CNT_EN
        check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif
        exp_pdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 0x81 with odd parity (bit 1)
        send_frame(8'h81, 6'd8, 8, 1'b1, 1'b1, 1'b1, 1'b1, K_DV);
        wait_drain();

`ifdef RX_ERR_CNT_EN
        check("err_cnt_after_rst", {24'd0, err_cnt}, 32'd0);
        for (int k = 0; k < 300; k++) begin
            send_frame(8'h0F, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b0, K_SE);
        end
        wait_drain();
        check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Receive-side stage of the UART link. Consumes the serial line driven by the UART transmitter (TX_OUT, idle-high, LSB-first, optional parity, one stop bit). Oversamples it, majority-votes each bit and checks parity and stop. Delivers the parallel byte with a one-cycle valid strobe to the downstream data-sync / register-file path.

Parameters:
data_width, 8, payload bits per frame.

Ports:
clk  input  1  oversampling clock (Prescale x baud).
rst  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line; idle = 1; already synchronised to clk.
PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
Prescale  input  6  oversampling ratio; 8, 16 or 32 are legal, any other value is treated as 8.
P_DATA  output  data_width  last correctly received byte.
data_valid  output  1  one-cycle strobe: P_DATA has just been updated.
parity_error  output  1  one-cycle strobe: frame rejected on parity.
stop_error  output  1  one-cycle strobe: frame rejected on stop bit.

Behaviour:
- Reset values: P_DATA = 0, all strobes = 0, FSM = IDLE, all counters = 0.
- Reset is asynchronous. Asserting it mid-frame aborts the frame with no strobe.
- Counters:
  - edge_cnt runs 0..Prescale-1 within each bit period.
  - bit_idx counts bit periods within the frame.
  - Prescale is sampled only in IDLE and held for the whole frame.
- Sampling:
  - RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1 (P = effective prescale).
  - Bit value = majority of the three captures.
  - The bit decision is taken at edge_cnt = P-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: the first cycle with RX_IN = 0 is edge 0 of the start bit -> START.
  - START: voted value 1 is a glitch -> back to IDLE, no strobe. Voted value 0 -> DATA.
  - DATA: data_width bits, shifted in LSB first. After the last bit, go to PARITY if PAR_EN = 1, else STOP.
  - PARITY: compare the voted bit with the computed parity (XOR of data, inverted when PAR_TYP = 1). Latch the mismatch -> STOP.
  - STOP: at edge P-1 evaluate the frame -> IDLE.
- STOP outcome, registered so the strobe is high in the next cycle, for exactly 1 cycle:
  - Voted stop = 0: stop_error = 1; P_DATA is unchanged.
  - Else, parity mismatch: parity_error = 1; P_DATA is unchanged.
  - Else: P_DATA = shifted byte and data_valid = 1.
  - stop_error takes priority. data_valid is never high together with an error strobe.
- Latency: frame length N bits (10, or 11 with parity). Strobe is high in cycle N*P, counting the first low sample as cycle 0.
- Back-to-back frames: IDLE may detect a new start in the same cycle the strobe is high, so there is no dead cycle.
- PAR_EN and PAR_TYP are sampled in IDLE and held per frame.

Optional Feature:
Macro RX_ERR_CNT_EN.
- Defined: adds output err_cnt, 8 bits, reset 0. It increments on every parity_error or stop_error strobe and saturates at 255. It is cleared only by reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Prescale = 8, PAR_EN = 1, PAR_TYP = 0, byte 0xA5 (parity bit 0) -> data_valid high only in cycle 88, P_DATA = 0xA5, no errors.
- Prescale = 16, PAR_EN = 0, bytes 0x3C then 0xFF sent back-to-back -> data_valid in cycles 160 and 320, P_DATA = 0x3C then 0xFF.
- Prescale = 8, PAR_TYP = 1, byte 0x01 sent with a wrong parity bit of 1 -> parity_error pulse in cycle 88, P_DATA keeps its previous value, data_valid stays 0.
- Stop bit forced to 0 with the parity bit also wrong -> stop_error only, parity_error = 0.
- RX_IN low for 3 clocks then high, Prescale = 8 -> returns to IDLE, no strobes. A following valid frame of 0x55 is received correctly.
- rst asserted during bit 4 of a frame -> all outputs 0 immediately. A clean 0x81 frame afterwards yields data_valid with P_DATA = 0x81. With RX_ERR_CNT_EN defined, 300 bad frames leave err_cnt = 255.
